// File: rtl/preg_pkg.sv
// Shared types for the two-entry pipeline register.
// State encoding and occupancy helper.
package preg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic logic [1:0] occupancy(input state_e s);
    return (s == TWO) ? 2'd2 :
           (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/preg_skid.sv
// Two-entry pipeline register with skid buffer,
// synchronous flush and saturating drop counter.
module preg_skid
  import preg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int FLUSH_ZERO = 1
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

  localparam int SW = CNT_WIDTH + 2;

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  vld_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [SW-1:0]         sum;
  logic                  accept;
  logic                  send;
  logic                  ld_main;
  logic                  ld_skid;
  logic                  mv_skid;

  assign o_ready    = (state_q != TWO);
  assign o_full     = (state_q == TWO);
  assign o_valid    = vld_q;
  assign o_data     = main_q;
  assign o_drop_cnt = cnt_q;

  assign accept = i_valid & o_ready;
  assign send   = vld_q & i_ready;

  // Widened sum so a +2 can never wrap before saturating.
  assign sum   = SW'(cnt_q) + SW'(occupancy(state_q));
  assign cnt_d = (|sum[SW-1:CNT_WIDTH]) ? '1
               : sum[CNT_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (1'b1)
        (state_q == EMPTY): begin
          if (accept) begin
            ld_main = 1'b1;
            state_d = ONE;
          end
        end
        (state_q == ONE): begin
          if (accept && send) begin
            ld_main = 1'b1;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = TWO;
          end else if (send) begin
            state_d = EMPTY;
          end
        end
        (state_q == TWO): begin
          if (send) begin
            mv_skid = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d != EMPTY);
      if (i_flush) begin
        cnt_q <= cnt_d;
        if (FLUSH_ZERO != 0) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        if (ld_main) begin
          main_q <= i_data;
        end else if (mv_skid) begin
          main_q <= skid_q;
        end
        if (ld_skid) begin
          skid_q <= i_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_preg_skid.sv
// Bench for preg_skid: directed scenarios plus
// random traffic against a queue reference model.
module tb_preg_skid;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] data = '0;

  logic        ov, ordy, ofull;
  logic [15:0] od;
  logic [15:0] ocnt;
  logic        v2, r2, f2;
  logic [15:0] d2;
  logic [1:0]  c2;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  int          mcnt = 0;

  always #5 clk = ~clk;

  preg_skid #(
    .DATA_WIDTH(16), .CNT_WIDTH(16), .FLUSH_ZERO(1)
  ) dut (
    .i_clk(clk), .i_arst(arst), .i_flush(flush),
    .i_valid(valid), .o_ready(ordy), .i_data(data),
    .o_valid(ov), .i_ready(ready), .o_data(od),
    .o_full(ofull), .o_drop_cnt(ocnt)
  );

  preg_skid #(
    .DATA_WIDTH(16), .CNT_WIDTH(2), .FLUSH_ZERO(0)
  ) dut2 (
    .i_clk(clk), .i_arst(arst), .i_flush(flush),
    .i_valid(valid), .o_ready(r2), .i_data(data),
    .o_valid(v2), .i_ready(ready), .o_data(d2),
    .o_full(f2), .o_drop_cnt(c2)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Drive one cycle and advance the queue model.
  task automatic cycle(input logic f, input logic v,
                       input logic r,
                       input logic [15:0] d);
    logic acc, snd;
    flush = f; valid = v; ready = r; data = d;
    @(posedge clk);
    if (f) begin
      mcnt += mq.size();
      mq.delete();
    end else begin
      acc = v && (mq.size() < 2);
      snd = (mq.size() > 0) && r;
      if (snd) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ov !== 1'b0) begin n_err++;
      $display("FAIL rst_valid got %0h want 0", ov); end
    n_cmp++; if (ordy !== 1'b1) begin n_err++;
      $display("FAIL rst_ready got %0h want 1", ordy); end
    n_cmp++; if (ofull !== 1'b0) begin n_err++;
      $display("FAIL rst_full got %0h want 0", ofull); end
    n_cmp++; if (ocnt !== 16'd0) begin n_err++;
      $display("FAIL rst_cnt got %0h want 0", ocnt); end
    n_cmp++; if (od !== 16'd0) begin n_err++;
      $display("FAIL rst_data got %0h want 0", od); end
    arst = 1'b0;
    mq.delete();
    mcnt = 0;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 16'(i));
      n_cmp++;
      if (ov !== 1'b1 || od !== 16'(i)) begin n_err++;
        $display("FAIL stream_%0d got v=%0h d=%0h want v=1 d=%0h",
                 i, ov, od, i); end
      n_cmp++; if (ordy !== 1'b1) begin n_err++;
        $display("FAIL stream_rdy_%0d got %0h want 1", i, ordy); end
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    n_cmp++; if (ov !== 1'b0) begin n_err++;
      $display("FAIL stream_drain got %0h want 0", ov); end
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 1'b1, 1'b0, 16'hA);
    cycle(1'b0, 1'b1, 1'b0, 16'hB);
    n_cmp++;
    if (ofull !== 1'b1 || ordy !== 1'b0 || od !== 16'hA) begin
      n_err++;
      $display("FAIL bp_full got f=%0h r=%0h d=%0h want 1 0 a",
               ofull, ordy, od); end
    cycle(1'b0, 1'b1, 1'b0, 16'hC);
    n_cmp++; if (od !== 16'hA || ofull !== 1'b1) begin n_err++;
      $display("FAIL bp_hold got d=%0h f=%0h want a 1",
               od, ofull); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    n_cmp++;
    if (od !== 16'hB || ov !== 1'b1 || ofull !== 1'b0) begin
      n_err++;
      $display("FAIL bp_second got d=%0h v=%0h f=%0h want b 1 0",
               od, ov, ofull); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    n_cmp++; if (ov !== 1'b0) begin n_err++;
      $display("FAIL bp_empty got %0h want 0", ov); end
  endtask

  task automatic test_flush_full();
    cycle(1'b0, 1'b1, 1'b0, 16'hA);
    cycle(1'b0, 1'b1, 1'b0, 16'hB);
    cycle(1'b1, 1'b1, 1'b1, 16'h55);
    n_cmp++; if (ov !== 1'b0 || od !== 16'h0) begin n_err++;
      $display("FAIL flush_out got v=%0h d=%0h want 0 0", ov, od); end
    n_cmp++; if (ocnt !== 16'd2) begin n_err++;
      $display("FAIL flush_cnt got %0d want 2", ocnt); end
    n_cmp++; if (c2 !== 2'd2) begin n_err++;
      $display("FAIL flush_cnt2 got %0d want 2", c2); end
    n_cmp++; if (d2 !== 16'hA || v2 !== 1'b0) begin n_err++;
      $display("FAIL flush_keep got d=%0h v=%0h want a 0",
               d2, v2); end
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    n_cmp++; if (ov !== 1'b0) begin n_err++;
      $display("FAIL flush_nostore got %0h want 0", ov); end
  endtask

  task automatic test_flush_empty();
    cycle(1'b1, 1'b1, 1'b0, 16'h77);
    n_cmp++; if (ov !== 1'b0 || ordy !== 1'b1) begin n_err++;
      $display("FAIL fe_state got v=%0h r=%0h want 0 1", ov, ordy); end
    n_cmp++; if (ocnt !== 16'd2) begin n_err++;
      $display("FAIL fe_cnt got %0d want 2", ocnt); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h10);
      cycle(1'b0, 1'b1, 1'b0, 16'h20);
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      n_cmp++; if (c2 !== 2'd3) begin n_err++;
        $display("FAIL sat_cnt2_%0d got %0d want 3", k, c2); end
      n_cmp++; if (ocnt !== 16'(mcnt)) begin n_err++;
        $display("FAIL sat_cnt_%0d got %0d want %0d",
                 k, ocnt, mcnt); end
    end
  endtask

  task automatic test_random();
    logic f;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 15) == 0);
      cycle(f, 1'($urandom), 1'($urandom), 16'($urandom));
      n_cmp++;
      if (ov !== (mq.size() > 0) || ordy !== (mq.size() < 2) ||
          ofull !== (mq.size() == 2)) begin n_err++;
        $display("FAIL rnd_flags_%0d got v%0h r%0h f%0h size %0d",
                 i, ov, ordy, ofull, mq.size()); end
      if (mq.size() > 0) begin
        n_cmp++;
        if (od !== mq[0] || d2 !== mq[0]) begin n_err++;
          $display("FAIL rnd_data_%0d got %0h/%0h want %0h",
                   i, od, d2, mq[0]); end
      end
      if (f) begin
        n_cmp++; if (od !== 16'h0) begin n_err++;
          $display("FAIL rnd_zero_%0d got %0h want 0", i, od); end
      end
      n_cmp++;
      if (ocnt !== 16'(sat(mcnt, 65535)) ||
          c2 !== 2'(sat(mcnt, 3))) begin n_err++;
        $display("FAIL rnd_cnt_%0d got %0d/%0d want %0d",
                 i, ocnt, c2, mcnt); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 16'h11);
    cycle(1'b0, 1'b1, 1'b0, 16'h22);
    n_cmp++; if (ofull !== 1'b1) begin n_err++;
      $display("FAIL rm_pre got %0h want 1", ofull); end
    #2 arst = 1'b1;
    #1;
    n_cmp++;
    if (ov !== 1'b0 || od !== 16'h0 || ordy !== 1'b1 ||
        ofull !== 1'b0) begin n_err++;
      $display("FAIL rm_out got v%0h d%0h r%0h f%0h want 0 0 1 0",
               ov, od, ordy, ofull); end
    n_cmp++; if (ocnt !== 16'd0 || c2 !== 2'd0) begin n_err++;
      $display("FAIL rm_cnt got %0d/%0d want 0", ocnt, c2); end
    @(posedge clk);
    #1 arst = 1'b0;
    mq.delete();
    mcnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 16'h42);
    n_cmp++; if (ov !== 1'b1 || od !== 16'h42) begin n_err++;
      $display("FAIL rm_after got v%0h d%0h want 1 42", ov, od); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_empty();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
